// File: rtl/systolic_feeder_2by2_pkg.sv
// Shared definitions for the 2x2 systolic kernel feeder: FSM states, weight
// addresses and the kernel's result latency.
package systolic_feeder_2by2_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } feeder_state_e;

    localparam logic [1:0] AddrW1 = 2'd0;
    localparam logic [1:0] AddrW2 = 2'd1;
    localparam logic [1:0] AddrW3 = 2'd2;
    localparam logic [1:0] AddrW4 = 2'd3;

    // Cycles from a real-data k_en cycle to its valid result in the 2x2 kernel
    localparam int unsigned DefaultLatency = 2;

endpackage

// File: rtl/feeder_vec_buffer.sv
// Vector-pair buffer for the systolic feeder. Stores up to Depth (row1, row2)
// pairs; the read port is combinational at rd_ptr. count only grows on writes
// and is cleared with the pointers when a block completes.
module feeder_vec_buffer #(
    parameter int unsigned DataSize = 8,
    parameter int unsigned Depth    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [DataSize-1:0]          wr_row1,
    input  logic [DataSize-1:0]          wr_row2,
    input  logic                         rd_en,
    output logic [DataSize-1:0]          rd_row1,
    output logic [DataSize-1:0]          rd_row2,
    output logic [$clog2(Depth+1)-1:0]   count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [CntW-1:0]       count_q;
    logic [2*DataSize-1:0] mem_q [Depth];

    // Storage array: data needs no reset, validity is tracked by count
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {wr_row1, wr_row2};
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (Depth is a power of 2)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
                count_q  <= count_q + CntW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    assign {rd_row1, rd_row2} = mem_q[rd_ptr_q];
    assign count              = count_q;

endmodule

// File: rtl/systolic_feeder_2by2.sv
// Transmit-side front end for the 2x2 systolic kernel. Buffers weights and a
// block of vector pairs while idle, then streams the block into the kernel one
// pair per cycle, drains the PE pipeline with zeros and flags valid results.
module systolic_feeder_2by2
    import systolic_feeder_2by2_pkg::*;
#(
    parameter int unsigned dataSize = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LATENCY  = DefaultLatency
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_addr,
    input  logic [dataSize-1:0] cfg_wdata,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [dataSize-1:0] s_row1,
    input  logic [dataSize-1:0] s_row2,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                k_en,
    output logic [dataSize-1:0] k_row1,
    output logic [dataSize-1:0] k_row2,
    output logic [dataSize-1:0] k_w1,
    output logic [dataSize-1:0] k_w2,
    output logic [dataSize-1:0] k_w3,
    output logic [dataSize-1:0] k_w4,
    output logic                res_valid
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned DrnW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    feeder_state_e       state_q;
    logic [CntW-1:0]     count;
    logic [CntW-1:0]     block_len;
    logic [CntW-1:0]     run_left_q;
    logic [DrnW-1:0]     drain_left_q;
    logic                wr_en;
    logic                rd_en;
    logic                buf_clear;
    logic [dataSize-1:0] rd_row1;
    logic [dataSize-1:0] rd_row2;
    logic [dataSize-1:0] first_row1;
    logic [dataSize-1:0] first_row2;
    logic [LATENCY-1:0]  res_sr_q;
    logic [LATENCY-1:0]  res_sr_d;

    assign busy      = (state_q != StIdle);
    assign s_ready   = (state_q == StIdle) && (count < CntW'(DEPTH));
    assign wr_en     = s_valid & s_ready;
    // A write in the start cycle joins the block
    assign block_len = count + CntW'(wr_en);
    assign buf_clear = (state_q == StDone);
    assign rd_en     = ((state_q == StIdle) && start && (block_len != '0)) ||
                       ((state_q == StRun) && (run_left_q != '0));
    // Empty buffer with a same-cycle write: the first pair is not stored yet
    assign first_row1 = (count == '0) ? s_row1 : rd_row1;
    assign first_row2 = (count == '0) ? s_row2 : rd_row2;

    feeder_vec_buffer #(
        .DataSize (dataSize),
        .Depth    (DEPTH)
    ) u_vec_buffer (
        .clk     (clk),
        .rst     (rst),
        .clear   (buf_clear),
        .wr_en   (wr_en),
        .wr_row1 (s_row1),
        .wr_row2 (s_row2),
        .rd_en   (rd_en),
        .rd_row1 (rd_row1),
        .rd_row2 (rd_row2),
        .count   (count)
    );

    // Block sequencer with registered kernel-side outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            run_left_q   <= '0;
            drain_left_q <= '0;
            k_en         <= 1'b0;
            k_row1       <= '0;
            k_row2       <= '0;
            done         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (block_len != '0) begin
                            state_q    <= StRun;
                            run_left_q <= block_len - CntW'(1);
                            k_en       <= 1'b1;
                            k_row1     <= first_row1;
                            k_row2     <= first_row2;
                        end else begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (run_left_q == '0) begin
                        state_q      <= StDrain;
                        drain_left_q <= DrnW'(LATENCY - 1);
                        k_row1       <= '0;
                        k_row2       <= '0;
                    end else begin
                        run_left_q <= run_left_q - CntW'(1);
                        k_row1     <= rd_row1;
                        k_row2     <= rd_row2;
                    end
                end
                StDrain: begin
                    if (drain_left_q == '0) begin
                        state_q <= StDone;
                        k_en    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        drain_left_q <= drain_left_q - DrnW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Weight registers, writable only while idle so they hold for a whole block
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_w1 <= '0;
            k_w2 <= '0;
            k_w3 <= '0;
            k_w4 <= '0;
        end else if ((state_q == StIdle) && cfg_we) begin
            unique case (cfg_addr)
                AddrW1: k_w1 <= cfg_wdata;
                AddrW2: k_w2 <= cfg_wdata;
                AddrW3: k_w3 <= cfg_wdata;
                AddrW4: k_w4 <= cfg_wdata;
                default: ;
            endcase
        end
    end

    // Result-valid delay line input: a 1 for every cycle a real pair is on k_row*
    always_comb begin
        res_sr_d    = res_sr_q << 1;
        res_sr_d[0] = (state_q == StRun);
    end

    // Result-valid delay line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_sr_q <= '0;
        end else begin
            res_sr_q <= res_sr_d;
        end
    end

    assign res_valid = res_sr_q[LATENCY-1];

endmodule

// File: tb/tb_systolic_feeder_2by2.sv
// Self-checking bench for systolic_feeder_2by2: a block-level model predicts
// every output each cycle, and directed literals pin the key cycles.
module tb_systolic_feeder_2by2;

    localparam int DW  = 8;
    localparam int DEP = 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_row1;
    logic [DW-1:0] s_row2;
    logic          start;
    logic          busy;
    logic          done;
    logic          k_en;
    logic [DW-1:0] k_row1;
    logic [DW-1:0] k_row2;
    logic [DW-1:0] k_w1;
    logic [DW-1:0] k_w2;
    logic [DW-1:0] k_w3;
    logic [DW-1:0] k_w4;
    logic          res_valid;

    always #5 clk = ~clk;

    systolic_feeder_2by2 #(
        .dataSize (DW),
        .DEPTH    (DEP),
        .LATENCY  (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_row1    (s_row1),
        .s_row2    (s_row2),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .k_en      (k_en),
        .k_row1    (k_row1),
        .k_row2    (k_row2),
        .k_w1      (k_w1),
        .k_w2      (k_w2),
        .k_w3      (k_w3),
        .k_w4      (k_w4),
        .res_valid (res_valid)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          busy;
        logic          en;
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
        logic          res;
        logic          done;
    } out_t;

    out_t            cur = '0;
    out_t            sched[$];
    logic [2*DW-1:0] mq[$];
    logic [DW-1:0]   mw[4];
    out_t            o;
    int              n;

    // Block schedule: n data cycles, LAT drain cycles, one done cycle
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            sched.delete();
            for (int i = 0; i < 4; i++) mw[i] = '0;
            cur = '0;
        end else begin
            if (!cur.busy) begin
                if (cfg_we) mw[cfg_addr] = cfg_wdata;
                if (s_valid && mq.size() < DEP) mq.push_back({s_row1, s_row2});
                if (start) begin
                    n = mq.size();
                    if (n == 0) begin
                        o = '0;
                        o.busy = 1'b1;
                        o.done = 1'b1;
                        sched.push_back(o);
                    end else begin
                        for (int j = 0; j < n + LAT + 1; j++) begin
                            o = '0;
                            o.busy = 1'b1;
                            o.en   = (j < n + LAT);
                            if (j < n) begin
                                o.r1 = mq[j][2*DW-1:DW];
                                o.r2 = mq[j][DW-1:0];
                            end
                            o.res  = (j >= LAT) && (j < n + LAT);
                            o.done = (j == n + LAT);
                            sched.push_back(o);
                        end
                    end
                    mq.delete();
                end
            end
            if (sched.size() > 0) cur = sched.pop_front();
            else cur = '0;
        end
    end

    // Compare every cycle out of reset
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("busy", busy, cur.busy);
            check("s_ready", s_ready, (!cur.busy) && (mq.size() < DEP));
            check("done", done, cur.done);
            check("k_en", k_en, cur.en);
            check("k_row1", k_row1, cur.r1);
            check("k_row2", k_row2, cur.r2);
            check("res_valid", res_valid, cur.res);
            check("k_w1", k_w1, mw[0]);
            check("k_w2", k_w2, mw[1]);
            check("k_w3", k_w3, mw[2]);
            check("k_w4", k_w4, mw[3]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_we  = 1'b0;
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic wr_weight(input logic [1:0] a, input logic [DW-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] r1, input logic [DW-1:0] r2);
        s_valid = 1'b1; s_row1 = r1; s_row2 = r2;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts remaining busy cycles, bounded
    task automatic wait_idle(output int k);
        k = 0;
        while (busy === 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check("block_ends", busy, 1'b0);
    endtask

    int e1[5] = '{1, 2, 3, 0, 0};
    int e2[5] = '{5, 6, 7, 0, 0};
    int er[5] = '{0, 0, 1, 1, 1};
    int k;

    initial begin
        idle_inputs();
        cfg_addr = '0; cfg_wdata = '0; s_row1 = '0; s_row2 = '0;
        #22 rst = 1'b1;
        tick();
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_k_en", k_en, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_k_w1", k_w1, 8'd0);

        // Test 1: basic three-pair block
        wr_weight(2'd0, 8'd1);
        wr_weight(2'd1, 8'd2);
        wr_weight(2'd2, 8'd3);
        wr_weight(2'd3, 8'd4);
        check("t1_w1", k_w1, 8'd1);
        check("t1_w4", k_w4, 8'd4);
        push(8'd1, 8'd5);
        push(8'd2, 8'd6);
        push(8'd3, 8'd7);
        kick();
        for (int j = 0; j < 5; j++) begin
            check("t1_k_en", k_en, 1'b1);
            check("t1_row1", k_row1, e1[j]);
            check("t1_row2", k_row2, e2[j]);
            check("t1_res", res_valid, er[j]);
            tick();
        end
        check("t1_done", done, 1'b1);
        check("t1_done_k_en", k_en, 1'b0);
        tick();
        check("t1_after_done", done, 1'b0);
        check("t1_after_busy", busy, 1'b0);

        // Test 2: full buffer drops the ninth pair
        for (int i = 0; i < DEP; i++) push(DW'(i + 1), DW'(8'h20 + i));
        s_valid = 1'b1; s_row1 = 8'hEE; s_row2 = 8'hEE;
        check("t2_full_ready", s_ready, 1'b0);
        tick();
        tick();
        s_valid = 1'b0;
        kick();
        check("t2_first_row1", k_row1, 8'd1);
        check("t2_first_row2", k_row2, 8'h20);
        wait_idle(k);
        check("t2_busy_len", k, DEP + LAT + 1);

        // Test 3: empty start
        kick();
        check("t3_done", done, 1'b1);
        check("t3_busy", busy, 1'b1);
        check("t3_k_en", k_en, 1'b0);
        tick();
        check("t3_busy_after", busy, 1'b0);
        check("t3_res", res_valid, 1'b0);

        // Test 4: inputs ignored while running
        push(8'd4, 8'd4);
        push(8'd5, 8'd5);
        kick();
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 8'd99;
        s_valid = 1'b1; s_row1 = 8'd7; s_row2 = 8'd7;
        start = 1'b1;
        check("t4_ready_busy", s_ready, 1'b0);
        tick();
        tick();
        check("t4_w1_held", k_w1, 8'd1);
        idle_inputs();
        wait_idle(k);
        check("t4_busy_tail", k, 3);
        check("t4_w1_after", k_w1, 8'd1);
        check("t4_ready_after", s_ready, 1'b1);

        // Test 5: asynchronous reset on the second RUN cycle
        push(8'd1, 8'd2);
        push(8'd3, 8'd4);
        kick();
        tick();
        check("t5_running", k_en, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_k_en", k_en, 1'b0);
        check("t5_rst_res", res_valid, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        #3 rst = 1'b1;
        #1;
        check("t5_ready", s_ready, 1'b1);
        tick();
        push(8'd9, 8'd9);
        kick();
        check("t5_row1", k_row1, 8'd9);
        check("t5_row2", k_row2, 8'd9);
        wait_idle(k);
        check("t5_busy_len", k, 1 + LAT + 1);

        // Test 6: back-to-back blocks, last write of block 2 with start
        push(8'h11, 8'h12);
        push(8'h13, 8'h14);
        kick();
        wait_idle(k);
        check("t6_b1_len", k, 2 + LAT + 1);
        push(8'h21, 8'h22);
        push(8'h23, 8'h24);
        s_valid = 1'b1; s_row1 = 8'h25; s_row2 = 8'h26;
        start = 1'b1;
        tick();
        idle_inputs();
        check("t6_b2_row1", k_row1, 8'h21);
        tick();
        tick();
        check("t6_b2_third", k_row2, 8'h26);
        wait_idle(k);
        check("t6_b2_tail", k, 1 + LAT + 1);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
